lsu: RTL

Load/store unit in the execute/memory boundary of the RISC-V core: consumes the effective address produced by the ALU (`ALU_ADD` of rs1 + imm) together with store data and funct3, issues one word-aligned request to data memory over a valid/ready handshake, waits for the read response, and returns byte/half/word-extracted, sign- or zero-extended load data for writeback. One access is in flight at a time; `busy` stalls the pipeline.

---
 rtl/lsu_pkg.sv | 86 ++++++++
 rtl/lsu_load_align.sv | 25 ++
 rtl/lsu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 encodings, FSM states,
// access-size decode and store lane helpers.
package lsu_pkg;

    localparam int LSU_DW = 32;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Unsigned loads have no store counterpart.
    function automatic logic lsu_legal(input logic we,
                                       input logic [2:0] f3);
        logic ok;
        case (f3)
            LSU_LB, LSU_LH, LSU_LW: ok = 1'b1;
            LSU_LBU, LSU_LHU:       ok = !we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only meaningful for legal encodings.
    function automatic lsu_size_t lsu_size(input logic [2:0] f3);
        lsu_size_t s;
        case (f3[1:0])
            2'b00:   s = SZ_B;
            2'b01:   s = SZ_H;
            default: s = SZ_W;
        endcase
        return s;
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_t s,
                                            input logic [1:0] off);
        logic m;
        case (s)
            SZ_H:    m = off[0];
            SZ_W:    m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lsu_wmask(input lsu_size_t s,
                                             input logic [1:0] off);
        logic [3:0] m;
        case (s)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = 4'b0011 << {off[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] lsu_wlanes(input lsu_size_t s,
                                               input logic [31:0] d);
        logic [31:0] r;
        case (s)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: shifts the read word down by the byte offset and
// sign/zero-extends per funct3. Ports: rdata, offset, funct3 -> data.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [LSU_DW-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [LSU_DW-1:0] data
);

    logic [LSU_DW-1:0] sh;

    always_comb begin
        sh = rdata >> {offset, 3'b000};
        unique case (funct3)
            LSU_LB:  data = {{24{sh[7]}}, sh[7:0]};
            LSU_LH:  data = {{16{sh[15]}}, sh[15:0]};
            LSU_LBU: data = {24'd0, sh[7:0]};
            LSU_LHU: data = {16'd0, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one word-aligned memory access in flight, valid/ready
// request side, one-cycle response pulse with extended load data.
// Ports: req_* from execute, mem_* to data memory, resp_* to writeback,
// busy stalls the pipeline. Macro LSU_MISALIGN_TRAP_EN enables faults
// on misaligned/illegal accesses; otherwise offending low address bits
// are cleared and illegal funct3 executes as a word access.
module lsu
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DWIDTH-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_fault,
    output logic              busy
);

    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DWIDTH-1:0] ld_data;

    logic              legal;
    logic              fault;
    lsu_size_t         size;
    logic [2:0]        f3n;
    logic [DWIDTH-1:0] addrn;
    logic              accept;

    assign accept = req_valid && req_ready;

    // Normalise the incoming request before it is latched.
    always_comb begin
        legal = lsu_legal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        f3n   = req_funct3;
        size  = lsu_size(f3n);
        addrn = req_addr;
        fault = !legal || lsu_misaligned(size, req_addr[1:0]);
`else
        f3n   = legal ? req_funct3 : (req_we ? LSU_SW : LSU_LW);
        size  = lsu_size(f3n);
        addrn = req_addr;
        case (size)
            SZ_H:    addrn[0]   = 1'b0;
            SZ_W:    addrn[1:0] = 2'b00;
            default: addrn      = req_addr;
        endcase
        fault = 1'b0;
`endif
    end

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;
    assign resp_fault = fault_q;
`else
    assign resp_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LSU_IDLE;
            req_ready     <= 1'b0;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wmask     <= 4'b0000;
            mem_wdata     <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_rd       <= 5'd0;
            we_q          <= 1'b0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                LSU_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        we_q      <= req_we;
                        f3_q      <= f3n;
                        off_q     <= addrn[1:0];
                        resp_rd   <= req_rd;
                        resp_data <= '0;
                        if (fault) begin
                            // Trapped access skips memory entirely.
                            state      <= LSU_RESP;
                            resp_valid <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            fault_q    <= 1'b1;
`endif
                        end else begin
                            state         <= LSU_ISSUE;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {addrn[DWIDTH-1:2], 2'b00};
                            mem_we        <= req_we;
                            if (req_we) begin
                                mem_wmask <= lsu_wmask(size, addrn[1:0]);
                                mem_wdata <= lsu_wlanes(size, req_wdata);
                            end else begin
                                mem_wmask <= 4'b0000;
                                mem_wdata <= '0;
                            end
                        end
                    end
                end
                LSU_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (we_q) begin
                            state      <= LSU_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (mem_rsp_valid) begin
                        state      <= LSU_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= ld_data;
                    end
                end
                LSU_RESP: begin
                    state      <= LSU_IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    fault_q    <= 1'b0;
`endif
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule
